adc_sar_control: RTL and testbench
==================================

# adc_sar_control

Successive-approximation controller for the 12-bit capacitive SAR ADC. It sequences sampling, per-bit DAC trial codes and comparator strobes, then resolves the 12-bit result MSB-first. Its `dac_data_out` drives the row/column thermometer decoder of the capacitor matrix directly. The result goes to the digital readout.

## Interface
Parameters:
- `SAMPLE_CYCLES`, 4: cycles `sample_out` is held high per conversion; legal range 1..15.
- `SETTLE_CYCLES`, 1: DAC settling cycles between a trial-code update and the comparator strobe; legal range 1..7.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_in`  in  1  level; sampled only in IDLE, starts one conversion.
- `continuous_in`  in  1  sampled in DONE; 1 = restart a conversion immediately.
- `comp_in`  in  1  comparator result; 1 = Vin > Vdac (keep the trial bit).
- `sample_out`  out  1  sampling switch enable.
- `comp_strobe_out`  out  1  one-cycle comparator latch strobe.
- `dac_data_out`  out  12  trial code to the row/col decoder: [11:8] row, [7:3] col, [2:0] binary caps.
- `result_out`  out  12  last completed conversion; held until the next DONE.
- `result_valid_out`  out  1  one-cycle pulse when `result_out` updates.
- `busy_out`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered (Moore) and derived from state and internal registers. There are no combinational input-to-output paths.
- FSM states: IDLE, SAMPLE, SETTLE, COMPARE, DECIDE, DONE.
- Internal registers:
  - `bit_idx` (4 bit): current bit, 11 down to 0.
  - `sar_reg` (12 bit): bits resolved so far.
  - `cnt` (4 bit): cycle counter within SAMPLE and SETTLE.
- IDLE:
  - `dac_data_out` = 12'h800; all strobes low.
  - `start_in`=1 → SAMPLE, `cnt` cleared, `sar_reg` cleared.
- SAMPLE:
  - `sample_out`=1, `dac_data_out`=12'h800.
  - After `SAMPLE_CYCLES` cycles → SETTLE with `bit_idx`=11.
- SETTLE:
  - `dac_data_out` = `sar_reg` | (1 << `bit_idx`), the trial code.
  - After `SETTLE_CYCLES` cycles → COMPARE.
- COMPARE:
  - `comp_strobe_out`=1 for exactly one cycle; trial code held.
  - → DECIDE.
- DECIDE:
  - Sample `comp_in`. `sar_reg[bit_idx]` ← `comp_in`; lower bits stay 0.
  - If `bit_idx`=0 → DONE; else decrement `bit_idx` → SETTLE.
- DONE:
  - `result_out` ← final `sar_reg`; `result_valid_out`=1 for this single cycle.
  - `dac_data_out` = final code.
  - If `continuous_in`=1 → SAMPLE (`sar_reg` and `cnt` cleared); else → IDLE.
- `start_in` is ignored outside IDLE; there is no abort input.
- `comp_in` is ignored outside DECIDE.
- Reset values (apply at the first rising edge with `rst`=1, from any state):
  - state IDLE
  - `sample_out`=0, `comp_strobe_out`=0, `result_valid_out`=0, `busy_out`=0
  - `dac_data_out`=12'h800, `result_out`=12'h000
  - `sar_reg`=0, `bit_idx`=11, `cnt`=0
- Reset mid-conversion discards the partial result; `result_out` returns to 0.

## Timing
- Let edge k be the edge that samples `start_in`=1 in IDLE.
  - SAMPLE occupies the cycles after edges k .. k+`SAMPLE_CYCLES`−1.
  - Each bit takes `SETTLE_CYCLES`+2 cycles.
  - DONE (`result_valid_out`=1) is the cycle after edge k+`SAMPLE_CYCLES`+12·(`SETTLE_CYCLES`+2).
  - Defaults: the pulse is in the cycle after edge k+40; conversion period 41 cycles.
- Continuous mode: period is `SAMPLE_CYCLES`+12·(`SETTLE_CYCLES`+2)+1 cycles, with no IDLE gap.
- `comp_in` must be stable at the edge ending the DECIDE cycle, i.e. one cycle after the strobe cycle.
- `busy_out` rises in the cycle after edge k. It falls in the cycle after DONE when not continuing.
- `start_in` held high continuously with `continuous_in`=0: one IDLE cycle between conversions.

## Test plan
- Reset check: assert `rst` for 1 cycle mid-COMPARE → next cycle state IDLE, `dac_data_out`=12'h800, `result_out`=0, `busy_out`=0, and no `result_valid_out` pulse.
- Ideal-comparator model with Vin code 12'hA5C: pulse `start_in`, drive `comp_in` = (Vin > `dac_data_out`) → `result_out`=12'hA5C with the valid pulse exactly 40 cycles after the start edge. Check the trial sequence 800, C00, A00, B00, A80, …
- Boundaries: `comp_in` stuck 1 → 12'hFFF, last trial 12'hFFF. `comp_in` stuck 0 → 12'h000, trial codes 800, 400, 200, …, 001.
- Strobe accounting: count `comp_strobe_out` pulses = 12 per conversion and `sample_out` high cycles = `SAMPLE_CYCLES`. Repeat with `SAMPLE_CYCLES`=1, `SETTLE_CYCLES`=3 → period 1+60+1 edges as specified.
- Continuous mode: `continuous_in`=1 for 3 conversions with Vin codes 12'h001, 12'h7FF, 12'h800 → three results, valid pulses 41 cycles apart, `busy_out` never low.
- Ignored inputs: toggle `start_in` every cycle during a conversion and `comp_in` randomly outside DECIDE → result unaffected, no extra conversion started.

Source files
------------

// File: rtl/adc_sar_control.sv
// 12-bit SAR ADC sequencer: sample, per-bit DAC trial/settle/strobe/decide, MSB-first result.
// Registered (Moore) outputs; valid pulses SAMPLE_CYCLES+12*(SETTLE_CYCLES+2) cycles after the start edge; no backpressure.
module adc_sar_control #(
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic        continuous_in,
    input  logic        comp_in,
    output logic        sample_out,
    output logic        comp_strobe_out,
    output logic [11:0] dac_data_out,
    output logic [11:0] result_out,
    output logic        result_valid_out,
    output logic        busy_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_COMPARE,
        S_DECIDE,
        S_DONE
    } state_t;

    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_bit_idx;
    logic [3:0]  w_bit_idx_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [11:0] r_sar;
    logic [11:0] w_sar_nxt;
    logic [11:0] r_result;
    logic [11:0] w_result_nxt;
    logic [11:0] w_trial_nxt;
    logic [11:0] w_dac_nxt;

    logic        r_sample;
    logic        r_strobe;
    logic [11:0] r_dac;
    logic        r_valid;
    logic        r_busy;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_cnt_nxt     = r_cnt;
        w_sar_nxt     = r_sar;
        w_result_nxt  = r_result;
        unique case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_state_nxt = S_SAMPLE;
                    w_cnt_nxt   = 4'd0;
                    w_sar_nxt   = 12'd0;
                end
            end
            S_SAMPLE: begin
                if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt   = S_SETTLE;
                    w_cnt_nxt     = 4'd0;
                    w_bit_idx_nxt = 4'd11;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_COMPARE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_COMPARE: begin
                w_state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                // the trial bit is never set in r_sar, so OR-ing the decision in is enough
                w_sar_nxt = r_sar | (12'(comp_in) << r_bit_idx);
                if (r_bit_idx == 4'd0) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = w_sar_nxt;
                end else begin
                    w_state_nxt   = S_SETTLE;
                    w_bit_idx_nxt = r_bit_idx - 4'd1;
                    w_cnt_nxt     = 4'd0;
                end
            end
            S_DONE: begin
                if (continuous_in) begin
                    w_state_nxt = S_SAMPLE;
                    w_cnt_nxt   = 4'd0;
                    w_sar_nxt   = 12'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered copy lines up with the state it describes.
    always_comb begin
        w_trial_nxt = w_sar_nxt | (12'd1 << w_bit_idx_nxt);
        w_dac_nxt   = 12'h800;
        case (w_state_nxt)
            S_SETTLE, S_COMPARE, S_DECIDE: w_dac_nxt = w_trial_nxt;
            S_DONE:                        w_dac_nxt = w_sar_nxt;
            default:                       w_dac_nxt = 12'h800;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_idx <= 4'd11;
            r_cnt     <= 4'd0;
            r_sar     <= 12'd0;
            r_result  <= 12'd0;
            r_sample  <= 1'b0;
            r_strobe  <= 1'b0;
            r_dac     <= 12'h800;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sar     <= w_sar_nxt;
            r_result  <= w_result_nxt;
            r_sample  <= (w_state_nxt == S_SAMPLE);
            r_strobe  <= (w_state_nxt == S_COMPARE);
            r_dac     <= w_dac_nxt;
            r_valid   <= (w_state_nxt == S_DONE);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign sample_out       = r_sample;
    assign comp_strobe_out  = r_strobe;
    assign dac_data_out     = r_dac;
    assign result_out       = r_result;
    assign result_valid_out = r_valid;
    assign busy_out         = r_busy;

endmodule

// File: tb/tb_adc_sar_control.sv
// Bench for adc_sar_control: conversion-level timeline model checked every cycle, plus literal expectations.
// Two instances: defaults (4/1) and SAMPLE_CYCLES=1, SETTLE_CYCLES=3.
module tb_adc_sar_control;

    logic        clk;
    logic        rst;
    logic        start_i  [2];
    logic        cont_i   [2];
    logic        comp_i   [2];
    logic        sample_o [2];
    logic        strobe_o [2];
    logic        valid_o  [2];
    logic        busy_o   [2];
    logic [11:0] dac_o    [2];
    logic [11:0] result_o [2];

    adc_sar_control #(.SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .start_in(start_i[0]), .continuous_in(cont_i[0]), .comp_in(comp_i[0]),
        .sample_out(sample_o[0]), .comp_strobe_out(strobe_o[0]), .dac_data_out(dac_o[0]),
        .result_out(result_o[0]), .result_valid_out(valid_o[0]), .busy_out(busy_o[0]));

    adc_sar_control #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .start_in(start_i[1]), .continuous_in(cont_i[1]), .comp_in(comp_i[1]),
        .sample_out(sample_o[1]), .comp_strobe_out(strobe_o[1]), .dac_data_out(dac_o[1]),
        .result_out(result_o[1]), .result_valid_out(valid_o[1]), .busy_out(busy_o[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- model: a conversion is a timeline indexed by cycles since its start edge
    function automatic int s_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int b_of(input int i);
        return (i == 0) ? 3 : 5;
    endfunction
    function automatic int d_of(input int i);
        return s_of(i) + 12 * b_of(i);
    endfunction
    // trial code for bit b when the bits above b have already resolved to those of v
    function automatic logic [11:0] trial(input logic [11:0] v, input int b);
        int vv;
        vv = int'(v);
        return 12'((vv & ~((1 << (b + 1)) - 1)) | (1 << b));
    endfunction

    bit          m_init = 1'b0;
    bit          m_busy [2];
    int          m_ph   [2];
    logic [11:0] m_vin  [2];
    logic [11:0] m_res  [2];
    logic [11:0] cur_vin[2];
    int          cmode  [2];
    bit          tgl    [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_ph[i]   = 0;
                m_res[i]  = 12'h000;
            end else if (!m_busy[i]) begin
                if (start_i[i]) begin
                    m_busy[i] = 1'b1;
                    m_ph[i]   = 0;
                    m_vin[i]  = cur_vin[i];
                end
            end else if (m_ph[i] == d_of(i)) begin
                if (cont_i[i]) begin
                    m_ph[i]  = 0;
                    m_vin[i] = cur_vin[i];
                end else begin
                    m_busy[i] = 1'b0;
                end
            end else begin
                m_ph[i] = m_ph[i] + 1;
                if (m_ph[i] == d_of(i)) m_res[i] = m_vin[i];
            end
        end
        m_init = 1'b1;
    end

    task automatic check_inst(input int i);
        int p, s, bb, d, b, sub;
        bit inw;
        logic [11:0] edac;
        p = m_ph[i]; s = s_of(i); bb = b_of(i); d = d_of(i);
        inw = m_busy[i] && p >= s && p < d;
        b   = inw ? 11 - (p - s) / bb : 0;
        sub = inw ? (p - s) % bb : 0;
        if (!m_busy[i] || p < s) edac = 12'h800;
        else if (p == d)         edac = m_vin[i];
        else                     edac = trial(m_vin[i], b);
        chk($sformatf("busy%0d", i),   32'(busy_o[i]),   32'(m_busy[i]));
        chk($sformatf("sample%0d", i), 32'(sample_o[i]), 32'(m_busy[i] && p < s));
        chk($sformatf("strobe%0d", i), 32'(strobe_o[i]), 32'(inw && sub == bb - 2));
        chk($sformatf("valid%0d", i),  32'(valid_o[i]),  32'(m_busy[i] && p == d));
        chk($sformatf("result%0d", i), 32'(result_o[i]), 32'(m_res[i]));
        if (!(inw && sub == bb - 1)) chk($sformatf("dac%0d", i), 32'(dac_o[i]), 32'(edac));
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < 2; i++) check_inst(i);
        end
    end

    // ---------------- stimulus
    // Vin is taken as code+0.5 LSB, so "Vin > Vdac" is code >= dac and an ideal SAR lands exactly on code.
    function automatic logic comp_for(input int i);
        int p, s, bb, b, sub;
        bit inw;
        logic ideal;
        p = m_ph[i]; s = s_of(i); bb = b_of(i);
        inw   = m_busy[i] && p >= s && p < d_of(i);
        b     = inw ? 11 - (p - s) / bb : 0;
        sub   = inw ? (p - s) % bb : 0;
        ideal = inw && (m_vin[i] >= trial(m_vin[i], b));
        case (cmode[i])
            1:       return (inw && sub == bb - 1) ? ideal : 1'($urandom_range(0, 1));
            2:       return 1'b1;
            3:       return 1'b0;
            default: return ideal;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            comp_i[i] = comp_for(i);
            if (tgl[i]) start_i[i] = m_busy[i] ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    int          r_lat, r_ns, r_nstb;
    logic [11:0] r_res;
    logic [11:0] r_tr[12];

    task automatic conv(input int i, input logic [11:0] vin, input int mode, input bit tog);
        cur_vin[i] = vin; cmode[i] = mode; tgl[i] = tog; start_i[i] = 1'b1;
        step();
        if (!tog) start_i[i] = 1'b0;
        r_lat = -1; r_ns = 0; r_nstb = 0; r_res = 12'h000;
        for (int c = 1; c <= 300; c++) begin
            if (sample_o[i]) r_ns++;
            if (strobe_o[i]) begin
                if (r_nstb < 12) r_tr[r_nstb] = dac_o[i];
                r_nstb++;
            end
            if (valid_o[i]) begin
                r_lat = c - 1;
                r_res = result_o[i];
                break;
            end
            step();
        end
        if (r_lat < 0) chk($sformatf("timeout%0d", i), 32'd0, 32'd1);
        step();
        tgl[i] = 1'b0; start_i[i] = 1'b0; cmode[i] = 0;
        chk($sformatf("busy_fall%0d", i), 32'(busy_o[i]), 32'd0);
    endtask

    initial begin
        logic [11:0] seq_a5c [5];
        logic [11:0] vins [3];
        int stamp[3];
        logic [11:0] cres[3];
        int c, nlow, nvalid;
        bit found;
        seq_a5c = '{12'h800, 12'hC00, 12'hA00, 12'hB00, 12'hA80};
        vins    = '{12'h001, 12'h7FF, 12'h800};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0; cont_i[i] = 1'b0; comp_i[i] = 1'b0;
            cur_vin[i] = 12'h000; cmode[i] = 0; tgl[i] = 1'b0;
        end
        step(); step(); step();
        chk("rst_dac", 32'(dac_o[0]), 32'h800);
        chk("rst_result", 32'(result_o[0]), 32'h000);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        step();

        // ideal comparator, default timing
        conv(0, 12'hA5C, 0, 1'b0);
        chk("a5c_result", 32'(r_res), 32'hA5C);
        chk("a5c_latency", 32'(r_lat), 32'd40);
        chk("a5c_sample_cycles", 32'(r_ns), 32'd4);
        chk("a5c_strobes", 32'(r_nstb), 32'd12);
        for (int k = 0; k < 5; k++) chk($sformatf("a5c_trial%0d", k), 32'(r_tr[k]), 32'(seq_a5c[k]));

        // comparator stuck high / stuck low
        conv(0, 12'hFFF, 2, 1'b0);
        chk("stuck1_result", 32'(r_res), 32'hFFF);
        chk("stuck1_last_trial", 32'(r_tr[11]), 32'hFFF);
        conv(0, 12'h000, 3, 1'b0);
        chk("stuck0_result", 32'(r_res), 32'h000);
        for (int k = 0; k < 12; k++) chk($sformatf("stuck0_trial%0d", k), 32'(r_tr[k]), 32'(12'h800 >> k));

        // short sample, long settle: 1 + 12*5 cycles to the pulse
        conv(1, 12'hA5C, 0, 1'b0);
        chk("alt_result", 32'(r_res), 32'hA5C);
        chk("alt_latency", 32'(r_lat), 32'd61);
        chk("alt_sample_cycles", 32'(r_ns), 32'd1);
        chk("alt_strobes", 32'(r_nstb), 32'd12);

        // continuous mode, three back-to-back conversions
        cur_vin[0] = vins[0]; cont_i[0] = 1'b1; start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        c = 0; nlow = 0;
        for (int n = 0; n < 3; n++) begin
            found = 1'b0;
            stamp[n] = 0; cres[n] = 12'h000;
            for (int t = 0; t < 200; t++) begin
                if (!busy_o[0]) nlow++;
                if (valid_o[0]) begin
                    stamp[n] = c; cres[n] = result_o[0]; found = 1'b1;
                    if (n < 2) cur_vin[0] = vins[n + 1];
                    else       cont_i[0] = 1'b0;
                    step(); c++;
                    break;
                end
                step(); c++;
            end
            if (!found) chk($sformatf("cont_timeout%0d", n), 32'd0, 32'd1);
        end
        for (int n = 0; n < 3; n++) chk($sformatf("cont_result%0d", n), 32'(cres[n]), 32'(vins[n]));
        chk("cont_gap01", 32'(stamp[1] - stamp[0]), 32'd41);
        chk("cont_gap12", 32'(stamp[2] - stamp[1]), 32'd41);
        chk("cont_busy_low", 32'(nlow), 32'd0);
        chk("cont_busy_fall", 32'(busy_o[0]), 32'd0);

        // start toggling and comparator noise outside the decide cycle
        conv(0, 12'h5A3, 1, 1'b1);
        chk("noise_result", 32'(r_res), 32'h5A3);
        chk("noise_latency", 32'(r_lat), 32'd40);
        nlow = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (busy_o[0]) nlow++;
        end
        chk("noise_no_restart", 32'(nlow), 32'd0);

        // reset during the first compare
        cur_vin[0] = 12'h3C3; start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        for (int t = 0; t < 50 && !strobe_o[0]; t++) step();
        chk("rst_reached_compare", 32'(strobe_o[0]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_dac", 32'(dac_o[0]), 32'h800);
        chk("midrst_result", 32'(result_o[0]), 32'h000);
        chk("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk("midrst_valid", 32'(valid_o[0]), 32'd0);
        nvalid = 0;
        for (int t = 0; t < 60; t++) begin
            step();
            if (valid_o[0] || busy_o[0]) nvalid++;
        end
        chk("midrst_quiet", 32'(nvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
